uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal baud divider and a configurable transmit FIFO. Data width, parity mode and stop length are configurable; divisor, parity and stop are set at run time. The block sits between on-chip byte producers (valid/ready source) and the FPGA UART TX pin. It replaces the fixed-baud, single-word transmitter and its external baud-clock generator.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
FIFO_DEPTH, 16, transmit FIFO entries, power of two, >=2
DIV_W, 16, width of run-time baud divisor

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
tx_en  in  1  transmitter enable
baud_div  in  DIV_W  clocks per bit; values <4 are treated as 4
parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark(1), 4 space(0), 5..7 none
stop_mode  in  2  0 one stop bit, 1 one-and-half, 2 two, 3 one
data_in  in  DATA_BITS  word to send, LSB first
data_in_valid  in  1  source word valid
data_in_ready  out  1  FIFO can accept; = !full && tx_en
tx  out  1  serial line, idle high, registered
busy  out  1  frame in progress
fifo_level  out  $clog2(FIFO_DEPTH)+1  words held in FIFO

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active high, port rst.
- Reset values: tx=1, busy=0, fifo_level=0, data_in_ready=0 during rst, FIFO empty, FSM IDLE, counters 0.
- Push: a word is written when data_in_valid && data_in_ready on a rising edge. There is no bypass: a word pushed into an empty FIFO at cycle T is popped at T+1 at the earliest.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when tx_en=1 and the FIFO is not empty:
  - pop the head word into the shift register;
  - latch baud_div, parity_mode and stop_mode;
  - go to START; busy=1 and tx=0 from the next cycle.
- Config stability: config inputs are sampled only at frame start. Changes mid-frame have no effect on the current frame.
- Bit timing: every bit lasts exactly D clocks, D = max(baud_div,4). A down-counter is loaded with D-1 and the bit advances at 0.
- START to DATA: one bit time.
- DATA: sends DATA_BITS bits, LSB first. Goes to PARITY if the latched parity_mode is 1..4, else to STOP.
- Parity bit: even = XOR of data bits; odd = XNOR of data bits; mark = 1; space = 0.
- STOP: tx=1 for D, D + (D>>1), or 2D clocks for stop_mode 0/3, 1, 2 respectively.
- End of STOP, FIFO not empty and tx_en=1: the next START begins on the following cycle with no idle gap. busy stays 1.
- End of STOP, otherwise: go to IDLE, busy=0.
- tx_en deasserted mid-frame: the current frame completes; no further pops; FIFO contents are kept. data_in_ready=0 while tx_en=0.
- Full FIFO: data_in_ready=0 and the push is ignored. Push and pop in the same cycle: fifo_level unchanged.
- fifo_level: updated on the edge after a push or pop.
- rst asserted mid-frame: tx=1 on the next edge; FIFO flushed; frame aborted.

Optional Feature:
Macro UART_TX_CTS_EN.
- Defined:
  - adds input cts_n (1 bit, active low, asynchronous to clk);
  - cts_n passes through a 2-flop synchroniser;
  - IDLE pops only while the synchronised cts_n=0;
  - a frame already started always completes;
  - cts_n high during a back-to-back STOP end sends the FSM to IDLE instead.
- Undefined: no cts_n port; behaviour as above.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD/PAR_MARK/PAR_SPACE;
  - stop constants STOP_1/STOP_1P5/STOP_2;
  - the tx FSM state enum;
  - the minimum divisor constant (4).
- One sub-module, uart_sync_fifo (width DATA_BITS, depth FIFO_DEPTH). It holds the pointers, the full/empty logic and the level count, and is reusable by the matching receiver.

Test Plan:
- 8N1 with baud_div=10: push 0x55 → tx low for 10 clocks, then bits 1,0,1,0,1,0,1,0 at 10 clocks each, then high for 10; frame length 100 clocks; busy high 100 clocks.
- Even parity with data 0x07 → parity bit 1; odd parity with 0x07 → 0; mark parity → 1 regardless of data; DATA_BITS=5 with 0x1F gives 5 data bits then parity.
- stop_mode=1, baud_div=10 → stop high for 15 clocks. stop_mode=2 → 20 clocks. baud_div=2 → every bit lasts 4 clocks.
- FIFO flow control: hold tx_en=0 and drive valid with a rising pattern. Required response:
  - data_in_ready=0 while tx_en=0;
  - enable, push 16 words while the line is busy → level reaches 16, data_in_ready=0, 17th word not accepted;
  - all 16 words appear in order with no idle gap between frames.
- Drop tx_en during DATA bit 3 → current frame completes; next FIFO word is not sent; fifo_level unchanged. Re-raise tx_en → transmission resumes.
- Assert rst mid-DATA → tx=1, busy=0, fifo_level=0 on the next edge. With UART_TX_CTS_EN, cts_n=1 holds a queued word; releasing it starts transmission 3 clocks later.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter (and its receiver twin).
//   - parity mode codes, stop mode codes
//   - transmit FSM state enum
//   - minimum clocks per bit
//   - par_bit(): parity bit value for a mode given the XOR of the data bits
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam logic [1:0] STOP_1   = 2'd0;
  localparam logic [1:0] STOP_1P5 = 2'd1;
  localparam logic [1:0] STOP_2   = 2'd2;

  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // True when the mode code carries a parity bit (codes 5..7 behave as none).
  function automatic logic par_on(input logic [2:0] mode);
    return (mode >= PAR_EVEN) && (mode <= PAR_SPACE);
  endfunction

  // x is the XOR reduction of the data bits.
  function automatic logic par_bit(input logic [2:0] mode, input logic x);
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready byte stream from an on-chip producer.
//   data_in        word to send, LSB first on the line
//   data_in_valid  producer has a word
//   data_in_ready  transmitter FIFO accepts the word this cycle
// Modports: master = producer, slave = transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;

  modport master (output data_in, output data_in_valid, input  data_in_ready);
  modport slave  (input  data_in, input  data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO, first-word-fall-through read port.
//   clk, rst      clock, synchronous active-high reset (flushes pointers)
//   wr_en/wr_data write request; ignored while full
//   rd_en         pop the head; ignored while empty
//   rd_data       current head word (valid while !empty)
//   full/empty    status
//   level         words held, 0..DEPTH
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level   = wp - rp;
  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + (AW+1)'(1);
      if (do_rd) rp <= rp + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with internal baud divider and TX FIFO.
//   clk, rst     clock, synchronous active-high reset
//   tx_en        enable; gates FIFO pushes and frame starts
//   baud_div     clocks per bit (values < 4 act as 4), sampled at frame start
//   parity_mode  0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 none
//   stop_mode    0/3 one, 1 one-and-half, 2 two stop bits
//   src          valid/ready producer stream (uart_tx_fifo_if.slave)
//   cts_n        (only with UART_TX_CTS_EN) async active-low clear-to-send
//   tx           registered serial line, idle high
//   busy         frame in progress
//   fifo_level   words held in the FIFO
// Optional feature macro: UART_TX_CTS_EN adds cts_n flow control.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_en,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [2:0]                  parity_mode,
  input  logic [1:0]                  stop_mode,
  uart_tx_fifo_if.slave               src,
`ifdef UART_TX_CTS_EN
  input  logic                        cts_n,
`endif
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  // One extra bit so a two-stop-bit period (2*D) fits.
  localparam int CW  = DIV_W + 1;
  localparam int BIW = $clog2(DATA_BITS);

  tx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BIW-1:0]       bit_idx, bit_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par_v, par_n;
  logic [DIV_W-1:0]     lat_d, d_n;
  logic [2:0]           lat_par, pm_n;
  logic [1:0]           lat_stop, sm_n;
  logic                 tx_n;

  logic                 push, pop, full, empty;
  logic [DATA_BITS-1:0] head;
  logic                 cts_ok, start_ok;
  logic [DIV_W-1:0]     d_in;
  logic [CW-1:0]        d_ext, stop_len;
  logic                 tick, load;

  // ---------------------------------------------------------------- FIFO
  assign src.data_in_ready = tx_en && !full && !rst;
  assign push              = src.data_in_valid && src.data_in_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (src.data_in),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // ------------------------------------------------------ clear-to-send
`ifdef UART_TX_CTS_EN
  logic cts_s1, cts_s2;

  // Two-flop synchroniser; resets to "not clear" so nothing starts early.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= cts_n;
      cts_s2 <= cts_s1;
    end
  end
  assign cts_ok = !cts_s2;
`else
  assign cts_ok = 1'b1;
`endif

  assign start_ok = tx_en && !empty && cts_ok;

  // ------------------------------------------------------ bit timing
  assign d_in  = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign d_ext = {1'b0, lat_d};

  always_comb begin
    case (lat_stop)
      STOP_1P5: stop_len = d_ext + (d_ext >> 1);
      STOP_2:   stop_len = d_ext << 1;
      default:  stop_len = d_ext;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // ------------------------------------------------------ FSM next state
  // tx is registered from tx_n, so the line already shows the new bit in
  // the first cycle of each state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    par_n   = par_v;
    d_n     = lat_d;
    pm_n    = lat_par;
    sm_n    = lat_stop;
    tx_n    = tx;
    pop     = 1'b0;
    load    = 1'b0;
    tick    = (cnt == '0);

    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (start_ok) load = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          cnt_n   = d_ext - CW'(1);
          bit_n   = '0;
          tx_n    = sh[0];
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_n = d_ext - CW'(1);
          if (bit_idx == BIW'(DATA_BITS - 1)) begin
            if (par_on(lat_par)) begin
              state_n = ST_PARITY;
              tx_n    = par_v;
            end else begin
              state_n = ST_STOP;
              cnt_n   = stop_len - CW'(1);
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_idx + BIW'(1);
            sh_n  = sh >> 1;
            tx_n  = sh[1];
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n = ST_STOP;
          cnt_n   = stop_len - CW'(1);
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          // Back-to-back frames: next START follows with no idle cycle.
          if (start_ok) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Frame start: pop head and freeze the run-time configuration.
    if (load) begin
      pop     = 1'b1;
      state_n = ST_START;
      cnt_n   = {1'b0, d_in} - CW'(1);
      sh_n    = head;
      par_n   = par_bit(parity_mode, ^head);
      d_n     = d_in;
      pm_n    = parity_mode;
      sm_n    = stop_mode;
      tx_n    = 1'b0;
    end
  end

  // ------------------------------------------------------ state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      par_v    <= 1'b0;
      lat_d    <= DIV_W'(MIN_DIV);
      lat_par  <= PAR_NONE;
      lat_stop <= STOP_1;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      sh       <= sh_n;
      par_v    <= par_n;
      lat_d    <= d_n;
      lat_par  <= pm_n;
      lat_stop <= sm_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// Samples on the falling edge, drives on the falling edge.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [15:0] baud_div;
  logic [2:0]  parity_mode;
  logic [1:0]  stop_mode;
  logic        tx, busy;
  logic [4:0]  fifo_level;
`ifdef UART_TX_CTS_EN
  logic        cts_n;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_if #(.DATA_BITS(8)) src_if ();

  uart_tx_fifo #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (16),
    .DIV_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop_mode   (stop_mode),
    .src         (src_if),
`ifdef UART_TX_CTS_EN
    .cts_n       (cts_n),
`endif
    .tx          (tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line must hold v with busy high for exactly len samples (overrun is
  // caught by the following segment or the end-of-frame check).
  task automatic seg(input string tag, input logic v, input int len);
    int bad;
    bad = 0;
    repeat (len) begin
      if (tx !== v || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input int dv,
                             input logic par_en, input logic par_v,
                             input int stop_len, input logic next_start);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start seen"}, 32'(tx), 32'd0);
    seg({tag, " start"}, 1'b0, dv);
    for (int i = 0; i < 8; i++) seg($sformatf("%s d%0d", tag, i), d[i], dv);
    if (par_en) seg({tag, " parity"}, par_v, dv);
    seg({tag, " stop"}, 1'b1, stop_len);
    if (next_start) chk({tag, " next start {busy,tx}"}, 32'({busy, tx}), 32'b10);
    else            chk({tag, " idle {busy,tx}"},       32'({busy, tx}), 32'b01);
  endtask

  task automatic push1(input logic [7:0] d);
    src_if.data_in       = d;
    src_if.data_in_valid = 1'b1;
    @(negedge clk);
    src_if.data_in_valid = 1'b0;
  endtask

  task automatic push2(input logic [7:0] a, input logic [7:0] b);
    src_if.data_in       = a;
    src_if.data_in_valid = 1'b1;
    @(negedge clk);
    src_if.data_in       = b;
    @(negedge clk);
    src_if.data_in_valid = 1'b0;
  endtask

  task automatic cfg(input int div, input int pm, input int sm);
    baud_div    = 16'(div);
    parity_mode = 3'(pm);
    stop_mode   = 2'(sm);
  endtask

  initial begin
    rst                  = 1'b1;
    tx_en                = 1'b1;
    src_if.data_in       = '0;
    src_if.data_in_valid = 1'b0;
    cfg(10, 0, 0);
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset tx",    32'(tx), 32'd1);
    chk("reset busy",  32'(busy), 32'd0);
    chk("reset level", 32'(fifo_level), 32'd0);
    chk("reset ready", 32'(src_if.data_in_ready), 32'd0);
    rst   = 1'b0;
    tx_en = 1'b0;

    // Disabled: nothing accepted.
    src_if.data_in       = 8'h11;
    src_if.data_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("disabled ready", 32'(src_if.data_in_ready), 32'd0);
    chk("disabled level", 32'(fifo_level), 32'd0);
    src_if.data_in_valid = 1'b0;
    tx_en = 1'b1;

    // 8N1, D=10, no bypass from push to pop.
    push1(8'h55);
    chk("nobypass tx",    32'(tx), 32'd1);
    chk("nobypass level", 32'(fifo_level), 32'd1);
    check_frame("8n1", 8'h55, 10, 1'b0, 1'b0, 10, 1'b0);

    cfg(6, 1, 0); push1(8'h07); check_frame("even", 8'h07, 6, 1'b1, 1'b1, 6, 1'b0);
    cfg(6, 2, 0); push1(8'h07); check_frame("odd",  8'h07, 6, 1'b1, 1'b0, 6, 1'b0);
    cfg(6, 3, 0); push1(8'h00); check_frame("mark", 8'h00, 6, 1'b1, 1'b1, 6, 1'b0);
    cfg(6, 4, 0); push1(8'hFF); check_frame("space", 8'hFF, 6, 1'b1, 1'b0, 6, 1'b0);
    cfg(6, 7, 0); push1(8'h07); check_frame("par7", 8'h07, 6, 1'b0, 1'b0, 6, 1'b0);

    cfg(10, 0, 1); push1(8'hA5); check_frame("stop1p5", 8'hA5, 10, 1'b0, 1'b0, 15, 1'b0);
    cfg(10, 0, 2); push1(8'h5A); check_frame("stop2",   8'h5A, 10, 1'b0, 1'b0, 20, 1'b0);
    cfg(10, 0, 3); push1(8'hC3); check_frame("stop3",   8'hC3, 10, 1'b0, 1'b0, 10, 1'b0);
    cfg(2, 0, 0);  push1(8'h3C); check_frame("div2",    8'h3C, 4, 1'b0, 1'b0, 4, 1'b0);
    cfg(0, 1, 0);  push1(8'h81); check_frame("div0",    8'h81, 4, 1'b1, 1'b0, 4, 1'b0);

    // Config changed mid-frame must not affect the frame in flight.
    cfg(8, 1, 0);
    push1(8'h3C);
    fork
      begin
        repeat (3) @(negedge clk);
        cfg(20, 0, 2);
      end
    join_none
    check_frame("cfgstab", 8'h3C, 8, 1'b1, 1'b0, 8, 1'b0);
    cfg(10, 0, 0);

    // Fill the FIFO while a frame is on the line; 17th word rejected.
    push1(8'hFF);
    for (int i = 0; i < 16; i++) begin
      src_if.data_in       = 8'(8'hA0 + i);
      src_if.data_in_valid = 1'b1;
      @(negedge clk);
    end
    src_if.data_in_valid = 1'b0;
    chk("full level", 32'(fifo_level), 32'd16);
    chk("full ready", 32'(src_if.data_in_ready), 32'd0);
    src_if.data_in       = 8'hEE;
    src_if.data_in_valid = 1'b1;
    @(negedge clk);
    src_if.data_in_valid = 1'b0;
    chk("full 17th level", 32'(fifo_level), 32'd16);
    for (int i = 0; i < 16; i++)
      check_frame($sformatf("flow%0d", i), 8'(8'hA0 + i), 10, 1'b0, 1'b0, 10, i < 15);

    // Drop tx_en during data bit 3; frame completes, next word held.
    push2(8'h96, 8'h69);
    fork
      begin
        repeat (44) @(negedge clk);
        tx_en = 1'b0;
      end
    join_none
    check_frame("endrop", 8'h96, 10, 1'b0, 1'b0, 10, 1'b0);
    chk("endrop level", 32'(fifo_level), 32'd1);
    chk("endrop ready", 32'(src_if.data_in_ready), 32'd0);
    repeat (30) @(negedge clk);
    chk("endrop hold {busy,tx}", 32'({busy, tx}), 32'b01);
    chk("endrop hold level", 32'(fifo_level), 32'd1);
    tx_en = 1'b1;
    check_frame("resume", 8'h69, 10, 1'b0, 1'b0, 10, 1'b0);

    // Reset mid-frame aborts and flushes.
    push2(8'h33, 8'hCC);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst {busy,tx}", 32'({busy, tx}), 32'b01);
    chk("midrst level",     32'(fifo_level), 32'd0);
    chk("midrst ready",     32'(src_if.data_in_ready), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("postrst {busy,tx}", 32'({busy, tx}), 32'b01);
    chk("postrst level",     32'(fifo_level), 32'd0);

`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    push1(8'h4B);
    repeat (10) @(negedge clk);
    chk("cts hold {busy,tx}", 32'({busy, tx}), 32'b01);
    chk("cts hold level",     32'(fifo_level), 32'd1);
    cts_n = 1'b0;
    @(negedge clk);
    chk("cts +1 tx", 32'(tx), 32'd1);
    @(negedge clk);
    chk("cts +2 tx", 32'(tx), 32'd1);
    @(negedge clk);
    chk("cts +3 tx", 32'(tx), 32'd0);
    check_frame("cts", 8'h4B, 10, 1'b0, 1'b0, 10, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
